// File: rtl/ber_checker.sv
// Bit-error-rate checker: finds the alignment delay between a local PRBS reference
// and the received bit stream, then counts compared bits and mismatches once locked.
// Timing: one result per strobe (enable & valid); sync_done rises the cycle after the last search strobe.
module ber_checker #(
  parameter int MAX_DELAY   = 511,
  parameter int SYNC_WINDOW = 511,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         valid,
  input  logic                         ref_bit,
  input  logic                         rx_bit,
  input  logic                         resync,
  output logic                         sync_done,
  output logic [$clog2(MAX_DELAY)-1:0] latency,
  output logic [CNT_WIDTH-1:0]         bit_count,
  output logic [CNT_WIDTH-1:0]         err_count
);

  localparam int LAT_W  = $clog2(MAX_DELAY);
  localparam int WC_W   = (SYNC_WINDOW > 1) ? $clog2(SYNC_WINDOW) : 1;
  localparam int WE_W   = $clog2(SYNC_WINDOW + 1);
  // Past reference bits; the current ref_bit acts as tap 0, so one fewer bit is stored.
  localparam int HIST_W = MAX_DELAY - 1;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [HIST_W-1:0]    hist_q, hist_d;
  logic [LAT_W-1:0]     cand_q, cand_d;
  logic [WC_W-1:0]      win_cnt_q, win_cnt_d;
  logic [WE_W-1:0]      win_err_q, win_err_d;
  logic [WE_W-1:0]      best_err_q, best_err_d;
  logic [LAT_W-1:0]     best_dly_q, best_dly_d;
  logic [LAT_W-1:0]     latency_q, latency_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic              strobe;
  logic [HIST_W:0]   taps;
  logic [LAT_W-1:0]  tap_sel;
  logic              mismatch;
  logic [WE_W-1:0]   win_err_nxt;
  logic              win_last;
  logic              cand_last;
  logic              new_best;

  assign strobe      = enable & valid;
  assign taps        = {hist_q, ref_bit};
  // While searching compare against the candidate under test, once locked against the chosen delay.
  assign tap_sel     = (state_q == LOCKED) ? latency_q : cand_q;
  assign mismatch    = rx_bit ^ taps[tap_sel];
  assign win_err_nxt = win_err_q + WE_W'(mismatch);
  assign win_last    = (win_cnt_q == WC_W'(SYNC_WINDOW - 1));
  assign cand_last   = (cand_q == LAT_W'(MAX_DELAY - 1));
  // Strictly-less keeps the earlier (lower) delay on a tie.
  assign new_best    = (win_err_nxt < best_err_q);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: resync always restarts the search; the last strobe of the last window locks.
  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = SEARCH;
    end else if (strobe && (state_q == SEARCH) && win_last && cand_last) begin
      state_d = LOCKED;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    sync_done = (state_q == LOCKED);
  end

  // Search bookkeeping, history shift and locked-mode counters.
  always_comb begin
    hist_d     = hist_q;
    cand_d     = cand_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    best_err_d = best_err_q;
    best_dly_d = best_dly_q;
    latency_d  = latency_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;

    // History advances on every strobe, even one swallowed by resync.
    if (strobe) begin
      hist_d = taps[HIST_W-1:0];
    end

    if (resync) begin
      cand_d     = '0;
      win_cnt_d  = '0;
      win_err_d  = '0;
      best_err_d = '1;
      best_dly_d = '0;
      bit_cnt_d  = '0;
      err_cnt_d  = '0;
    end else if (strobe) begin
      if (state_q == SEARCH) begin
        if (win_last) begin
          if (new_best) begin
            best_err_d = win_err_nxt;
            best_dly_d = cand_q;
          end
          win_cnt_d = '0;
          win_err_d = '0;
          if (cand_last) begin
            cand_d    = '0;
            latency_d = new_best ? cand_q : best_dly_q;
          end else begin
            cand_d = cand_q + LAT_W'(1);
          end
        end else begin
          win_cnt_d = win_cnt_q + WC_W'(1);
          win_err_d = win_err_nxt;
        end
      end else begin
        // Counters stick at all-ones rather than wrapping.
        if (bit_cnt_q != '1) begin
          bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
        end
        if (mismatch && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q     <= '0;
      cand_q     <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      best_err_q <= '1;
      best_dly_q <= '0;
      latency_q  <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      hist_q     <= hist_d;
      cand_q     <= cand_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      best_err_q <= best_err_d;
      best_dly_q <= best_dly_d;
      latency_q  <= latency_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign latency   = latency_q;
  assign bit_count = bit_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: PRBS9 reference with a delayed / corrupted rx stream,
// directed scenarios plus randomized strobe patterns, checked every cycle against
// a per-candidate error-tally model.
module tb_ber_checker;

  localparam int MD = 16;
  localparam int SW = 32;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        valid;
  logic        ref_bit;
  logic        rx_bit;
  logic        resync;
  logic        sync_done;
  logic [3:0]  latency;
  logic [15:0] bit_count;
  logic [15:0] err_count;
  logic        sync4;
  logic [3:0]  lat4;
  logic [3:0]  bc4;
  logic [3:0]  ec4;

  ber_checker #(.MAX_DELAY(MD), .SYNC_WINDOW(SW), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .valid(valid),
    .ref_bit(ref_bit), .rx_bit(rx_bit), .resync(resync),
    .sync_done(sync_done), .latency(latency),
    .bit_count(bit_count), .err_count(err_count)
  );

  ber_checker #(.MAX_DELAY(MD), .SYNC_WINDOW(SW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .valid(valid),
    .ref_bit(ref_bit), .rx_bit(rx_bit), .resync(resync),
    .sync_done(sync4), .latency(lat4),
    .bit_count(bc4), .err_count(ec4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: every reference bit seen since reset, plus search/lock bookkeeping.
  bit     refs[$];
  bit     searching;
  int     k;
  int     errs[MD];
  int     lat;
  longint bits;
  longint errc;
  logic [8:0] lfsr = 9'h001;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit tapm(input int g, input int d, input bit rb);
    if (d == 0) return rb;
    if (g - d >= 0) return refs[g - d];
    return 1'b0;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    refs.delete();
    searching = 1'b1;
    k = 0;
    foreach (errs[i]) errs[i] = 0;
    lat  = 0;
    bits = 0;
    errc = 0;
  endtask

  task automatic model_step(input bit strobe, input bit rs, input bit rb, input bit rx);
    int g;
    int bd;
    g = refs.size();
    if (rs) begin
      searching = 1'b1;
      k = 0;
      foreach (errs[i]) errs[i] = 0;
      bits = 0;
      errc = 0;
    end else if (strobe) begin
      if (searching) begin
        errs[k / SW] += int'(rx ^ tapm(g, k / SW, rb));
        k++;
        if (k == MD * SW) begin
          bd = 0;
          for (int d = 1; d < MD; d++) if (errs[d] < errs[bd]) bd = d;
          lat = bd;
          searching = 1'b0;
        end
      end else begin
        bits++;
        errc += longint'(rx ^ tapm(g, lat, rb));
      end
    end
    if (strobe) refs.push_back(rb);
  endtask

  task automatic check_all();
    chk("sync_done", 64'(sync_done), 64'(!searching));
    chk("latency",   64'(latency),   64'(lat));
    chk("bit_count", 64'(bit_count), 64'(sat(bits, 16)));
    chk("err_count", 64'(err_count), 64'(sat(errc, 16)));
    chk("sync4",     64'(sync4),     64'(!searching));
    chk("lat4",      64'(lat4),      64'(lat));
    chk("bit4",      64'(bc4),       64'(sat(bits, 4)));
    chk("err4",      64'(ec4),       64'(sat(errc, 4)));
  endtask

  // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
  task automatic tick(input bit en, input bit vl, input bit rs, input int dly, input bit flip);
    bit rb;
    bit rx;
    rb = lfsr[8];
    rx = tapm(refs.size(), dly, rb) ^ flip;
    enable  = en;
    valid   = vl;
    resync  = rs;
    ref_bit = rb;
    rx_bit  = rx;
    model_step(en && vl, rs, rb, rx);
    if (en && vl) lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int dly;
    int n;
    reset = 1'b1; enable = 1'b0; valid = 1'b0;
    ref_bit = 1'b0; rx_bit = 1'b0; resync = 1'b0;
    model_reset();
    #1;
    chk("rst_sync",  64'(sync_done), 64'd0);
    chk("rst_lat",   64'(latency),   64'd0);
    chk("rst_bits",  64'(bit_count), 64'd0);
    chk("rst_errs",  64'(err_count), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Aligned search with rx = ref delayed 5 strobes, one strobe per cycle.
    for (int i = 0; i < MD * SW; i++) tick(1, 1, 0, 5, 0);
    chk("lock_sync", 64'(sync_done), 64'd1);
    chk("lock_lat",  64'(latency),   64'd5);
    for (int i = 0; i < 20; i++) tick(1, 1, 0, 5, 0);
    chk("clean_bits", 64'(bit_count), 64'd20);
    chk("clean_errs", 64'(err_count), 64'd0);
    for (int i = 0; i < 30; i++) tick(1, 1, 0, 5, (i == 3) || (i == 10) || (i == 17));
    chk("flip_errs", 64'(err_count), 64'd3);
    chk("flip_bits", 64'(bit_count), 64'd50);

    // Resync while locked, new delay 9.
    tick(1, 1, 1, 9, 0);
    chk("resync_sync", 64'(sync_done), 64'd0);
    chk("resync_bits", 64'(bit_count), 64'd0);
    chk("resync_lat",  64'(latency),   64'd5);
    for (int i = 0; i < MD * SW; i++) tick(1, 1, 0, 9, 0);
    chk("relock_lat9", 64'(latency), 64'd9);

    // valid toggling: 512 strobes take 1024 cycles.
    tick(1, 1, 1, 5, 0);
    for (int i = 0; i < 2 * MD * SW; i++) tick(1, (i % 2) == 0, 0, 5, 0);
    chk("vtog_sync", 64'(sync_done), 64'd1);
    chk("vtog_lat",  64'(latency),   64'd5);
    for (int i = 0; i < 10; i++) tick(1, (i % 2) == 0, 0, 5, 0);
    chk("vtog_bits", 64'(bit_count), 64'd5);

    // enable toggling instead.
    tick(1, 1, 1, 5, 0);
    for (int i = 0; i < 2 * MD * SW; i++) tick((i % 2) == 0, 1, 0, 5, 0);
    chk("etog_lat", 64'(latency), 64'd5);
    for (int i = 0; i < 10; i++) tick((i % 2) == 0, 1, 0, 5, 0);
    chk("etog_bits", 64'(bit_count), 64'd5);

    // Asynchronous reset 200 strobes into a search.
    tick(1, 1, 1, 7, 0);
    for (int i = 0; i < 200; i++) tick(1, 1, 0, 7, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sync", 64'(sync_done), 64'd0);
    chk("arst_lat",  64'(latency),   64'd0);
    chk("arst_bits", 64'(bit_count), 64'd0);
    chk("arst_errs", 64'(err_count), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < MD * SW; i++) tick(1, 1, 0, 5, 0);
    chk("arst_relock", 64'(latency), 64'd5);

    // Inverted rx after lock: narrow counters saturate.
    for (int i = 0; i < 20; i++) tick(1, 1, 0, 5, 1);
    chk("sat_bits4", 64'(bc4),       64'd15);
    chk("sat_errs4", 64'(ec4),       64'd15);
    chk("inv_bits",  64'(bit_count), 64'd20);
    chk("inv_errs",  64'(err_count), 64'd20);

    // Randomized strobe patterns, delays and bit errors.
    for (int r = 0; r < 2; r++) begin
      dly = $urandom_range(0, MD - 1);
      tick(1, 1, 1, dly, 0);
      n = 0;
      while (searching && n < 3000) begin
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 0, dly,
             $urandom_range(0, 7) == 0);
        n++;
      end
      chk("rand_locked", 64'(searching), 64'd0);
      for (int i = 0; i < 100; i++)
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 0, dly,
             $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
